frame_buffer_arbiter: RTL and testbench
=======================================

Name: frame_buffer_arbiter

Overview:
- Shares the single DRAM frame-buffer command/write port between two requesters, all on clk_pixel:
  - the display line-prefetch reader (deadline-critical);
  - the effect write-back path (delay/reverb frame history).
- Sequences each grant as one command, plus one fixed-length write burst for writes.
- Sits between the video processing chain and the memory-controller FIFO interface.
- Bounded write starvation; urgent reads always win.

Parameters:
- ADDR_WIDTH, 27, DRAM burst address width.
- DATA_WIDTH, 16, write beat width (one RGB565 pixel).
- BURST_LEN, 16, beats per write burst; power of two, ≥2.
- MAX_WR_STARVE, 4, consecutive non-urgent read grants allowed while a write waits.

Ports:
- clk_pixel  in  1  pixel clock.
- rst  in  1  reset; synchronous, active-high.
- rd_req_valid  in  1  line-prefetch read request.
- rd_req_addr  in  ADDR_WIDTH  read burst address.
- rd_urgent  in  1  line buffer below low watermark.
- rd_req_ready  out  1  read request accepted this cycle.
- wr_req_valid  in  1  write-back request.
- wr_req_addr  in  ADDR_WIDTH  write burst address.
- wr_req_ready  out  1  write request accepted this cycle.
- wr_data_in  in  DATA_WIDTH  write beat from requester.
- wr_data_in_valid  in  1  beat valid.
- wr_data_in_ready  out  1  beat accepted.
- mem_cmd_valid  out  1  command valid.
- mem_cmd_ready  in  1  controller accepts command.
- mem_cmd_write  out  1  1 = write, 0 = read.
- mem_cmd_addr  out  ADDR_WIDTH  command address.
- mem_wdata  out  DATA_WIDTH  write beat.
- mem_wdata_valid  out  1  beat valid.
- mem_wdata_ready  in  1  controller accepts beat.
- mem_wdata_last  out  1  final beat of burst.
- new_frame  in  1  frame-start pulse (statistics only).
- stat_rd_grants  out  16  read grants in previous frame.
- stat_wr_grants  out  16  write grants in previous frame.
- stat_forced_wr  out  16  starvation-forced write grants in previous frame.

Behaviour:
- FSM states: IDLE, RD_CMD, WR_CMD, WR_DATA.
- Reset values:
  - state = IDLE; starve_cnt, beat_cnt = 0.
  - mem_cmd_valid, mem_cmd_write, mem_wdata_last, mem_wdata_valid = 0.
  - mem_cmd_addr = 0; all stat counters and stat outputs = 0.
  - rd_req_ready, wr_req_ready, wr_data_in_ready = 0 in reset cycle.
- IDLE grant priority, combinational, evaluated each cycle:
  1. rd_req_valid && rd_urgent → read.
  2. wr_req_valid && (starve_cnt == MAX_WR_STARVE || !rd_req_valid) → write.
  3. rd_req_valid → read.
  4. Otherwise idle.
- Grant handshake:
  - Grant asserts the matching *_req_ready combinationally in IDLE only.
  - Address is latched into mem_cmd_addr.
  - Next state is RD_CMD or WR_CMD.
  - mem_cmd_valid asserts the cycle after acceptance (1-cycle latency).
- RD_CMD / WR_CMD:
  - mem_cmd_valid = 1; mem_cmd_write = 0 or 1; address held stable until mem_cmd_ready.
  - On handshake: RD_CMD → IDLE; WR_CMD → WR_DATA with beat_cnt = 0.
  - Earliest back-to-back grant is the cycle after the handshake, so 2 cycles per read command.
- WR_DATA, combinational pass-through:
  - mem_wdata = wr_data_in; mem_wdata_valid = wr_data_in_valid; wr_data_in_ready = mem_wdata_ready.
  - mem_wdata_last = (beat_cnt == BURST_LEN-1).
  - beat_cnt increments on each valid&&ready.
  - Handshake on the last beat → IDLE.
  - Outside WR_DATA: wr_data_in_ready = 0 and mem_wdata_valid = 0.
- Starvation counter:
  - Increments, saturating at MAX_WR_STARVE, on each read grant made while wr_req_valid = 1.
  - Clears on write grant; otherwise holds.
  - Urgent reads still win when starve_cnt == MAX_WR_STARVE.
- Simultaneous requests with starve_cnt < MAX and no urgent → read wins.
- Requests arriving during RD_CMD/WR_CMD/WR_DATA wait; requesters hold valid and address until ready.
- Reset mid-burst: immediate return to IDLE; partial burst abandoned; memory controller is reset by the same rst.
- Statistics:
  - Live counters saturate at 16'hFFFF.
  - On new_frame: live counters copied to stat_*, then cleared.
  - A grant in the same cycle as new_frame counts toward the new frame.

Optional Feature:
- FB_ARB_STATS_EN:
  - Defined: statistics counters and new_frame handling are built as described.
  - Undefined: stat_* tied to 0, new_frame ignored, no counter logic synthesised.
  - Arbitration identical either way.

Decomposition:
- Shared package fb_arb_pkg:
  - fb_arb_state_t enum (IDLE, RD_CMD, WR_CMD, WR_DATA).
  - FB_ADDR_WIDTH, FB_DATA_WIDTH, FB_BURST_LEN constants.
- One natural sub-module, fb_arb_stats: three saturating counters with frame snapshot; instantiated only under FB_ARB_STATS_EN.

Test Plan:
- Only rd_req_valid, addr 0x100, mem_cmd_ready = 1 → rd_req_ready same cycle; next cycle mem_cmd_valid = 1, write = 0, addr = 0x100; back-to-back read command every 2 cycles.
- Write only, addr 0x200, 16 beats 0..15, mem_wdata_ready toggling 1/0 → exactly 16 beats pass in order; last asserted only on value 15; then IDLE.
- rd_req_valid held high (non-urgent) with wr_req_valid → 4 read grants, then forced write; stat_forced_wr = 1 after new_frame.
- Same as above with rd_urgent = 1 throughout → write never granted; starve_cnt holds at 4; first cycle rd_urgent drops, write granted.
- rst asserted at beat 7 of a write burst → next cycle all outputs 0, state IDLE; new write then completes a full 16-beat burst.
- mem_cmd_ready low for 10 cycles in RD_CMD → mem_cmd_addr and mem_cmd_valid stable; both ready outputs held 0.

Source files
------------

// File: rtl/fb_arb_pkg.sv
// -----------------------------------------------------------------------------
// fb_arb_pkg
// Shared types and constants for the frame-buffer arbiter slice.
//   fb_arb_state_t : arbiter FSM states (IDLE, RD_CMD, WR_CMD, WR_DATA)
//   FB_*           : default DRAM address / beat width and write burst length
//   fb_sat_inc16   : 16-bit saturating increment used by the statistics block
// -----------------------------------------------------------------------------
package fb_arb_pkg;

  localparam int FB_ADDR_WIDTH = 27;
  localparam int FB_DATA_WIDTH = 16;
  localparam int FB_BURST_LEN  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_CMD  = 2'd1,
    WR_CMD  = 2'd2,
    WR_DATA = 2'd3
  } fb_arb_state_t;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] fb_sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fb_arb_stats.sv
// -----------------------------------------------------------------------------
// fb_arb_stats
// Per-frame grant statistics: three saturating live counters that are copied
// to the stat_* outputs and cleared on each new_frame pulse. A grant arriving
// in the same cycle as new_frame is counted toward the new frame.
// Ports:
//   clk_pixel, rst      : pixel clock, synchronous active-high reset
//   rd_grant, wr_grant  : one-cycle grant strobes from the arbiter
//   forced_wr_grant     : write grant that pre-empted a pending read
//   new_frame           : frame-start pulse
//   stat_*              : counts captured for the previous frame
// -----------------------------------------------------------------------------
module fb_arb_stats
  import fb_arb_pkg::*;
(
  input  logic        clk_pixel,
  input  logic        rst,
  input  logic        rd_grant,
  input  logic        wr_grant,
  input  logic        forced_wr_grant,
  input  logic        new_frame,
  output logic [15:0] stat_rd_grants,
  output logic [15:0] stat_wr_grants,
  output logic [15:0] stat_forced_wr
);

  logic [15:0] live_rd_r;
  logic [15:0] live_wr_r;
  logic [15:0] live_forced_r;

  // Live counters plus frame snapshot registers.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      live_rd_r      <= 16'd0;
      live_wr_r      <= 16'd0;
      live_forced_r  <= 16'd0;
      stat_rd_grants <= 16'd0;
      stat_wr_grants <= 16'd0;
      stat_forced_wr <= 16'd0;
    end else if (new_frame) begin
      stat_rd_grants <= live_rd_r;
      stat_wr_grants <= live_wr_r;
      stat_forced_wr <= live_forced_r;
      live_rd_r      <= {15'd0, rd_grant};
      live_wr_r      <= {15'd0, wr_grant};
      live_forced_r  <= {15'd0, forced_wr_grant};
    end else begin
      live_rd_r      <= rd_grant        ? fb_sat_inc16(live_rd_r)     : live_rd_r;
      live_wr_r      <= wr_grant        ? fb_sat_inc16(live_wr_r)     : live_wr_r;
      live_forced_r  <= forced_wr_grant ? fb_sat_inc16(live_forced_r) : live_forced_r;
    end
  end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// frame_buffer_arbiter
// Shares the DRAM frame-buffer command/write port between the display line
// prefetch reader and the effect write-back path. Each grant issues one
// command; write grants are followed by a BURST_LEN-beat write burst.
// Urgent reads always win; a waiting write is forced through after
// MAX_WR_STARVE consecutive non-urgent read grants.
// Ports:
//   clk_pixel, rst                       : pixel clock, synchronous active-high reset
//   rd_req_* / rd_urgent                 : read request channel (ready = grant)
//   wr_req_*                             : write request channel (ready = grant)
//   wr_data_in*                          : write beats from the requester
//   mem_cmd_* / mem_wdata*               : memory-controller command and write data
//   new_frame, stat_*                    : per-frame grant statistics
// Build option: define FB_ARB_STATS_EN to build the statistics counters;
// without it stat_* are tied to zero and new_frame is ignored.
// -----------------------------------------------------------------------------
module frame_buffer_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH    = FB_DATA_WIDTH,
  parameter int BURST_LEN     = FB_BURST_LEN,
  parameter int MAX_WR_STARVE = 4
) (
  input  logic                  clk_pixel,
  input  logic                  rst,
  input  logic                  rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic                  rd_urgent,
  output logic                  rd_req_ready,
  input  logic                  wr_req_valid,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic                  wr_req_ready,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  input  logic                  wr_data_in_valid,
  output logic                  wr_data_in_ready,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_write,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wdata_valid,
  input  logic                  mem_wdata_ready,
  output logic                  mem_wdata_last,
  input  logic                  new_frame,
  output logic [15:0]           stat_rd_grants,
  output logic [15:0]           stat_wr_grants,
  output logic [15:0]           stat_forced_wr
);

  localparam int STARVE_W = $clog2(MAX_WR_STARVE + 1);
  localparam int BEAT_W   = $clog2(BURST_LEN);

  fb_arb_state_t       state_r;
  fb_arb_state_t       state_nxt_s;
  logic [BEAT_W-1:0]   beat_cnt_r;
  logic [BEAT_W-1:0]   beat_cnt_nxt_s;
  logic [STARVE_W-1:0] starve_cnt_r;
  logic                starve_max_s;
  logic                rd_grant_s;
  logic                wr_grant_s;
  logic                last_beat_s;

  assign starve_max_s = (starve_cnt_r == STARVE_W'(MAX_WR_STARVE));
  assign last_beat_s  = (beat_cnt_r == BEAT_W'(BURST_LEN - 1));

  // Grants only exist in IDLE and never while reset is asserted.
  assign rd_req_ready = rd_grant_s;
  assign wr_req_ready = wr_grant_s;

  // Command outputs follow the registered state, so valid rises the cycle
  // after the grant and stays up until the controller takes the command.
  assign mem_cmd_valid = (state_r == RD_CMD) || (state_r == WR_CMD);
  assign mem_cmd_write = (state_r == WR_CMD);

  // IDLE grant priority: urgent read, starved or lone write, plain read.
  always_comb begin
    rd_grant_s = 1'b0;
    wr_grant_s = 1'b0;
    if (!rst && (state_r == IDLE)) begin
      if (rd_req_valid && rd_urgent) begin
        rd_grant_s = 1'b1;
      end else if (wr_req_valid && (starve_max_s || !rd_req_valid)) begin
        wr_grant_s = 1'b1;
      end else if (rd_req_valid) begin
        rd_grant_s = 1'b1;
      end else begin
        rd_grant_s = 1'b0;
        wr_grant_s = 1'b0;
      end
    end else begin
      rd_grant_s = 1'b0;
      wr_grant_s = 1'b0;
    end
  end

  // Next state, beat counting and write-data pass-through.
  always_comb begin
    state_nxt_s      = state_r;
    beat_cnt_nxt_s   = beat_cnt_r;
    mem_wdata        = {DATA_WIDTH{1'b0}};
    mem_wdata_valid  = 1'b0;
    mem_wdata_last   = 1'b0;
    wr_data_in_ready = 1'b0;
    case (state_r)
      IDLE: begin
        if (rd_grant_s) begin
          state_nxt_s = RD_CMD;
        end else if (wr_grant_s) begin
          state_nxt_s = WR_CMD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_CMD: begin
        if (mem_cmd_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RD_CMD;
        end
      end
      WR_CMD: begin
        if (mem_cmd_ready) begin
          state_nxt_s    = WR_DATA;
          beat_cnt_nxt_s = {BEAT_W{1'b0}};
        end else begin
          state_nxt_s = WR_CMD;
        end
      end
      WR_DATA: begin
        mem_wdata        = wr_data_in;
        mem_wdata_valid  = wr_data_in_valid;
        wr_data_in_ready = mem_wdata_ready;
        mem_wdata_last   = last_beat_s;
        if (wr_data_in_valid && mem_wdata_ready) begin
          if (last_beat_s) begin
            state_nxt_s    = IDLE;
            beat_cnt_nxt_s = {BEAT_W{1'b0}};
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + BEAT_W'(1);
          end
        end else begin
          beat_cnt_nxt_s = beat_cnt_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counters and latched command address.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      state_r      <= IDLE;
      beat_cnt_r   <= {BEAT_W{1'b0}};
      starve_cnt_r <= {STARVE_W{1'b0}};
      mem_cmd_addr <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      // Only reads that bypass a waiting write count as starvation.
      if (wr_grant_s) begin
        starve_cnt_r <= {STARVE_W{1'b0}};
      end else if (rd_grant_s && wr_req_valid && !starve_max_s) begin
        starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
      if (rd_grant_s) begin
        mem_cmd_addr <= rd_req_addr;
      end else if (wr_grant_s) begin
        mem_cmd_addr <= wr_req_addr;
      end else begin
        mem_cmd_addr <= mem_cmd_addr;
      end
    end
  end

`ifdef FB_ARB_STATS_EN
  // A write granted while a read is also pending can only be the starvation
  // override, since a pending non-urgent read otherwise wins.
  logic forced_wr_s;
  assign forced_wr_s = wr_grant_s && rd_req_valid;

  fb_arb_stats u_stats (
    .clk_pixel       (clk_pixel),
    .rst             (rst),
    .rd_grant        (rd_grant_s),
    .wr_grant        (wr_grant_s),
    .forced_wr_grant (forced_wr_s),
    .new_frame       (new_frame),
    .stat_rd_grants  (stat_rd_grants),
    .stat_wr_grants  (stat_wr_grants),
    .stat_forced_wr  (stat_forced_wr)
  );
`else
  logic unused_new_frame_s;
  assign unused_new_frame_s = new_frame;
  assign stat_rd_grants     = 16'd0;
  assign stat_wr_grants     = 16'd0;
  assign stat_forced_wr     = 16'd0;
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_arbiter
// Directed bench for frame_buffer_arbiter. Expected commands and write beats
// are queued when requests are driven and popped when the DUT presents them.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_frame_buffer_arbiter;

  logic        clk_pixel = 1'b0;
  logic        rst = 1'b1;
  logic        rd_req_valid = 1'b0;
  logic [26:0] rd_req_addr = 27'd0;
  logic        rd_urgent = 1'b0;
  logic        rd_req_ready;
  logic        wr_req_valid = 1'b0;
  logic [26:0] wr_req_addr = 27'd0;
  logic        wr_req_ready;
  logic [15:0] wr_data_in = 16'd0;
  logic        wr_data_in_valid = 1'b0;
  logic        wr_data_in_ready;
  logic        mem_cmd_valid;
  logic        mem_cmd_ready = 1'b1;
  logic        mem_cmd_write;
  logic [26:0] mem_cmd_addr;
  logic [15:0] mem_wdata;
  logic        mem_wdata_valid;
  logic        mem_wdata_ready = 1'b1;
  logic        mem_wdata_last;
  logic        new_frame = 1'b0;
  logic [15:0] stat_rd_grants;
  logic [15:0] stat_wr_grants;
  logic [15:0] stat_forced_wr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [27:0] exp_cmds[$];   // {write, addr}
  logic [15:0] exp_beats[$];

  frame_buffer_arbiter dut (
    .clk_pixel        (clk_pixel),
    .rst              (rst),
    .rd_req_valid     (rd_req_valid),
    .rd_req_addr      (rd_req_addr),
    .rd_urgent        (rd_urgent),
    .rd_req_ready     (rd_req_ready),
    .wr_req_valid     (wr_req_valid),
    .wr_req_addr      (wr_req_addr),
    .wr_req_ready     (wr_req_ready),
    .wr_data_in       (wr_data_in),
    .wr_data_in_valid (wr_data_in_valid),
    .wr_data_in_ready (wr_data_in_ready),
    .mem_cmd_valid    (mem_cmd_valid),
    .mem_cmd_ready    (mem_cmd_ready),
    .mem_cmd_write    (mem_cmd_write),
    .mem_cmd_addr     (mem_cmd_addr),
    .mem_wdata        (mem_wdata),
    .mem_wdata_valid  (mem_wdata_valid),
    .mem_wdata_ready  (mem_wdata_ready),
    .mem_wdata_last   (mem_wdata_last),
    .new_frame        (new_frame),
    .stat_rd_grants   (stat_rd_grants),
    .stat_wr_grants   (stat_wr_grants),
    .stat_forced_wr   (stat_forced_wr)
  );

  // 10 ns pixel clock.
  always #5 clk_pixel = ~clk_pixel;

  // Hard stop in case a wait never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  // Called at a falling edge where a command must be on the bus.
  task automatic pop_cmd(input string tag);
    logic [27:0] e;
    e = (exp_cmds.size() != 0) ? exp_cmds.pop_front() : 28'hFFFFFFF;
    check({tag, "_cmd_valid"}, {31'd0, mem_cmd_valid}, 32'd1);
    check({tag, "_cmd_write"}, {31'd0, mem_cmd_write}, {31'd0, e[27]});
    check({tag, "_cmd_addr"}, {5'd0, mem_cmd_addr}, {5'd0, e[26:0]});
  endtask

  // Drive beats base+0.. while in WR_DATA until stop_at beats are accepted.
  task automatic feed_burst(input logic [15:0] base, input bit toggle, input int stop_at);
    int idx;
    logic [15:0] e;
    idx = 0;
    for (int i = 0; i < 16; i++) exp_beats.push_back(base + 16'(i));
    for (int cyc = 0; cyc < 80 && idx < stop_at; cyc++) begin
      mem_wdata_ready  = toggle ? ((cyc % 2) == 0) : 1'b1;
      wr_data_in       = base + 16'(idx);
      wr_data_in_valid = 1'b1;
      @(negedge clk_pixel);
      check("wdata_valid", {31'd0, mem_wdata_valid}, 32'd1);
      check("wdata_in_ready", {31'd0, wr_data_in_ready}, {31'd0, mem_wdata_ready});
      if (mem_wdata_valid && mem_wdata_ready) begin
        e = (exp_beats.size() != 0) ? exp_beats.pop_front() : 16'hFFFF;
        check("wdata", {16'd0, mem_wdata}, {16'd0, e});
        check("wlast", {31'd0, mem_wdata_last}, {31'd0, (idx == 15)});
        idx++;
      end
      tick();
    end
    check("beat_count", idx, stop_at);
    mem_wdata_ready = 1'b1;
  endtask

  initial begin
    // ---------------- reset ----------------
    rd_req_valid = 1'b1;
    rd_req_addr  = 27'h55;
    wr_req_valid = 1'b1;
    @(negedge clk_pixel);
    check("rst_rd_ready", {31'd0, rd_req_ready}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_req_ready}, 32'd0);
    check("rst_cmd_valid", {31'd0, mem_cmd_valid}, 32'd0);
    check("rst_cmd_write", {31'd0, mem_cmd_write}, 32'd0);
    check("rst_cmd_addr", {5'd0, mem_cmd_addr}, 32'd0);
    check("rst_wdata_valid", {31'd0, mem_wdata_valid}, 32'd0);
    check("rst_wlast", {31'd0, mem_wdata_last}, 32'd0);
    check("rst_stat_rd", {16'd0, stat_rd_grants}, 32'd0);
    check("rst_stat_forced", {16'd0, stat_forced_wr}, 32'd0);
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    tick();
    rst = 1'b0;

    // ---------------- back-to-back reads ----------------
    rd_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_req_addr = 27'h100 + 27'(i);
      @(negedge clk_pixel);
      check("rd_grant", {31'd0, rd_req_ready}, 32'd1);
      exp_cmds.push_back({1'b0, 27'h100 + 27'(i)});
      tick();
      @(negedge clk_pixel);
      pop_cmd("rd");
      check("rd_ready_in_cmd", {31'd0, rd_req_ready}, 32'd0);
      tick();
    end
    rd_req_valid = 1'b0;
    @(negedge clk_pixel);
    check("idle_cmd_valid", {31'd0, mem_cmd_valid}, 32'd0);
    tick();

    // ---------------- single write, toggling wdata_ready ----------------
    wr_req_valid = 1'b1;
    wr_req_addr  = 27'h200;
    @(negedge clk_pixel);
    check("wr_grant", {31'd0, wr_req_ready}, 32'd1);
    exp_cmds.push_back({1'b1, 27'h200});
    tick();
    wr_req_valid = 1'b0;
    @(negedge clk_pixel);
    pop_cmd("wr");
    tick();
    feed_burst(16'h0000, 1'b1, 16);
    @(negedge clk_pixel);
    check("post_burst_wvalid", {31'd0, mem_wdata_valid}, 32'd0);
    check("post_burst_in_ready", {31'd0, wr_data_in_ready}, 32'd0);
    check("post_burst_cmd_valid", {31'd0, mem_cmd_valid}, 32'd0);
    tick();
    wr_data_in_valid = 1'b0;

    // Close the frame so the next test counts from zero.
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;

    // ---------------- starvation: 4 reads then forced write ----------------
    rd_req_valid = 1'b1;
    rd_req_addr  = 27'h400;
    wr_req_valid = 1'b1;
    wr_req_addr  = 27'h600;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk_pixel);
      check("starve_rd_ready", {31'd0, rd_req_ready}, {31'd0, (g < 4)});
      check("starve_wr_ready", {31'd0, wr_req_ready}, {31'd0, (g == 4)});
      exp_cmds.push_back((g < 4) ? {1'b0, 27'h400} : {1'b1, 27'h600});
      tick();
      if (g == 4) begin
        rd_req_valid = 1'b0;
        wr_req_valid = 1'b0;
      end
      @(negedge clk_pixel);
      pop_cmd("starve");
      tick();
    end
    feed_burst(16'h0A00, 1'b0, 16);
    wr_data_in_valid = 1'b0;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    @(negedge clk_pixel);
`ifdef FB_ARB_STATS_EN
    check("stat_rd", {16'd0, stat_rd_grants}, 32'd4);
    check("stat_wr", {16'd0, stat_wr_grants}, 32'd1);
    check("stat_forced", {16'd0, stat_forced_wr}, 32'd1);
`else
    check("stat_rd", {16'd0, stat_rd_grants}, 32'd0);
    check("stat_wr", {16'd0, stat_wr_grants}, 32'd0);
    check("stat_forced", {16'd0, stat_forced_wr}, 32'd0);
`endif
    tick();

    // ---------------- urgent reads block writes ----------------
    rd_req_valid = 1'b1;
    rd_urgent    = 1'b1;
    rd_req_addr  = 27'h800;
    wr_req_valid = 1'b1;
    wr_req_addr  = 27'h700;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk_pixel);
      check("urgent_rd_ready", {31'd0, rd_req_ready}, 32'd1);
      check("urgent_wr_ready", {31'd0, wr_req_ready}, 32'd0);
      exp_cmds.push_back({1'b0, 27'h800});
      tick();
      @(negedge clk_pixel);
      pop_cmd("urgent");
      tick();
    end
    rd_urgent = 1'b0;
    @(negedge clk_pixel);
    check("unurgent_wr_ready", {31'd0, wr_req_ready}, 32'd1);
    check("unurgent_rd_ready", {31'd0, rd_req_ready}, 32'd0);
    exp_cmds.push_back({1'b1, 27'h700});
    tick();
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    @(negedge clk_pixel);
    pop_cmd("unurgent");
    tick();
    feed_burst(16'h0B00, 1'b0, 16);
    wr_data_in_valid = 1'b0;

    // ---------------- reset at beat 7 ----------------
    wr_req_valid = 1'b1;
    wr_req_addr  = 27'h300;
    @(negedge clk_pixel);
    check("rstburst_wr_grant", {31'd0, wr_req_ready}, 32'd1);
    exp_cmds.push_back({1'b1, 27'h300});
    tick();
    wr_req_valid = 1'b0;
    @(negedge clk_pixel);
    pop_cmd("rstburst");
    tick();
    feed_burst(16'h0C00, 1'b0, 7);
    wr_data_in       = 16'h0C07;
    wr_data_in_valid = 1'b1;
    wr_req_valid     = 1'b1;
    rst              = 1'b1;
    @(negedge clk_pixel);
    check("midrst_wr_ready", {31'd0, wr_req_ready}, 32'd0);
    tick();
    rst          = 1'b0;
    wr_req_valid = 1'b0;
    exp_beats.delete();
    @(negedge clk_pixel);
    check("afterrst_cmd_valid", {31'd0, mem_cmd_valid}, 32'd0);
    check("afterrst_cmd_write", {31'd0, mem_cmd_write}, 32'd0);
    check("afterrst_cmd_addr", {5'd0, mem_cmd_addr}, 32'd0);
    check("afterrst_wvalid", {31'd0, mem_wdata_valid}, 32'd0);
    check("afterrst_wlast", {31'd0, mem_wdata_last}, 32'd0);
    check("afterrst_in_ready", {31'd0, wr_data_in_ready}, 32'd0);
    check("afterrst_stat_rd", {16'd0, stat_rd_grants}, 32'd0);
    tick();
    wr_data_in_valid = 1'b0;
    wr_req_valid     = 1'b1;
    wr_req_addr      = 27'h340;
    @(negedge clk_pixel);
    check("rewr_grant", {31'd0, wr_req_ready}, 32'd1);
    exp_cmds.push_back({1'b1, 27'h340});
    tick();
    wr_req_valid = 1'b0;
    @(negedge clk_pixel);
    pop_cmd("rewr");
    tick();
    feed_burst(16'h0D00, 1'b1, 16);
    wr_data_in_valid = 1'b0;

    // ---------------- command back-pressure ----------------
    mem_cmd_ready = 1'b0;
    rd_req_valid  = 1'b1;
    rd_req_addr   = 27'h480;
    @(negedge clk_pixel);
    check("bp_rd_grant", {31'd0, rd_req_ready}, 32'd1);
    exp_cmds.push_back({1'b0, 27'h480});
    tick();
    rd_req_addr  = 27'h481;
    wr_req_valid = 1'b1;
    wr_req_addr  = 27'h500;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_pixel);
      check("bp_cmd_valid", {31'd0, mem_cmd_valid}, 32'd1);
      check("bp_cmd_addr", {5'd0, mem_cmd_addr}, 32'h480);
      check("bp_rd_ready", {31'd0, rd_req_ready}, 32'd0);
      check("bp_wr_ready", {31'd0, wr_req_ready}, 32'd0);
      tick();
    end
    mem_cmd_ready = 1'b1;
    @(negedge clk_pixel);
    pop_cmd("bp");
    tick();
    // Both pending, no starvation yet: read wins.
    @(negedge clk_pixel);
    check("tie_rd_ready", {31'd0, rd_req_ready}, 32'd1);
    check("tie_wr_ready", {31'd0, wr_req_ready}, 32'd0);
    exp_cmds.push_back({1'b0, 27'h481});
    tick();
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    @(negedge clk_pixel);
    pop_cmd("tie");
    tick();

    check("cmd_queue_drained", exp_cmds.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
